dds_key_ctrl: RTL and testbench

- Upstream control stage of the DDS generator.
- Debounces the three active-low push keys.
- Turns confirmed presses into the registered DDS control words: waveform select, frequency tuning word and phase offset word.
- Outputs feed the phase accumulator and waveform ROM address logic directly.

---
 rtl/dds_key_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_dds_key_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/dds_key_ctrl.sv
// Key front end for the DDS generator: synchronises and debounces three active-low
// keys and steps the waveform select, frequency tuning word and phase offset word.
// Optional key1 auto-repeat is built when DDS_KEY_AUTO_REPEAT_EN is defined.
module dds_key_ctrl #(
  parameter int unsigned DEBOUNCE_CYC = 1_000_000,
  parameter logic [31:0] FREQ_BASE    = 32'd85899,
  parameter int unsigned FREQ_IDX_MAX = 7,
  parameter logic [11:0] PHASE_STEP   = 12'd1024
`ifdef DDS_KEY_AUTO_REPEAT_EN
  ,
  parameter int unsigned REPEAT_CYC   = 25_000_000
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key0_in,
  input  logic        key1_in,
  input  logic        key2_in,
  output logic [1:0]  wave_sel,
  output logic [31:0] freq_word,
  output logic [11:0] phase_word,
  output logic [2:0]  key_evt
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned IDX_W = (FREQ_IDX_MAX > 0) ? $clog2(FREQ_IDX_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(FREQ_IDX_MAX);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FILT_DN = 2'd1,
    ST_DOWN    = 2'd2,
    ST_FILT_UP = 2'd3
  } deb_state_e;

  // Counter never wraps: once at all-ones it stays there.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_SAT) begin
      return v;
    end else begin
      return v + CNT_W'(1);
    end
  endfunction

  logic [2:0]       key_raw_s;
  logic [2:0]       sync1_q;
  logic [2:0]       sync_q;
  deb_state_e       state_q [3];
  deb_state_e       state_d [3];
  logic [CNT_W-1:0] cnt_q   [3];
  logic [CNT_W-1:0] cnt_d   [3];
  logic [2:0]       press_s;
  logic             rpt_s;

  logic [2:0]       key_evt_q, key_evt_d;
  logic [1:0]       wave_sel_q, wave_sel_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      freq_word_q, freq_word_d;
  logic [11:0]      phase_word_q, phase_word_d;

  assign key_raw_s = {key2_in, key1_in, key0_in};

  // Two-stage synchroniser, preset to the released level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 3'b111;
      sync_q  <= 3'b111;
    end else begin
      sync1_q <= key_raw_s;
      sync_q  <= sync1_q;
    end
  end

  // Per-key debounce next-state; press_s marks the FILT_DN -> DOWN transition.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      state_d[k] = state_q[k];
      cnt_d[k]   = cnt_q[k];
      press_s[k] = 1'b0;
      case (state_q[k])
        ST_IDLE: begin
          if (!sync_q[k]) begin
            state_d[k] = ST_FILT_DN;
            cnt_d[k]   = CNT_ZERO;
          end else begin
            state_d[k] = ST_IDLE;
          end
        end
        ST_FILT_DN: begin
          if (sync_q[k]) begin
            state_d[k] = ST_IDLE;
            cnt_d[k]   = CNT_ZERO;
          end else if (cnt_q[k] == CNT_LAST) begin
            state_d[k] = ST_DOWN;
            press_s[k] = 1'b1;
          end else begin
            cnt_d[k] = sat_inc(cnt_q[k]);
          end
        end
        ST_DOWN: begin
          if (sync_q[k]) begin
            state_d[k] = ST_FILT_UP;
            cnt_d[k]   = CNT_ZERO;
          end else begin
            state_d[k] = ST_DOWN;
          end
        end
        ST_FILT_UP: begin
          if (!sync_q[k]) begin
            state_d[k] = ST_DOWN;
          end else if (cnt_q[k] == CNT_LAST) begin
            state_d[k] = ST_IDLE;
            cnt_d[k]   = CNT_ZERO;
          end else begin
            cnt_d[k] = sat_inc(cnt_q[k]);
          end
        end
        default: begin
          state_d[k] = ST_IDLE;
          cnt_d[k]   = CNT_ZERO;
        end
      endcase
    end
  end

  // Debounce state and filter counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        state_q[k] <= ST_IDLE;
        cnt_q[k]   <= CNT_ZERO;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
    end
  end

`ifdef DDS_KEY_AUTO_REPEAT_EN
  localparam int unsigned RPT_W = $clog2(REPEAT_CYC + 1);
  localparam logic [RPT_W-1:0] RPT_ZERO = {RPT_W{1'b0}};
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYC - 1);

  logic [RPT_W-1:0] hold_q, hold_d;

  // Hold timer for key1: restarts after each repeat, cleared once the key leaves DOWN.
  always_comb begin
    hold_d = hold_q;
    rpt_s  = 1'b0;
    if ((state_q[1] == ST_DOWN) && (state_d[1] == ST_DOWN)) begin
      if (hold_q == RPT_LAST) begin
        hold_d = RPT_ZERO;
        rpt_s  = 1'b1;
      end else begin
        hold_d = hold_q + RPT_W'(1);
      end
    end else begin
      hold_d = RPT_ZERO;
    end
  end

  // Hold timer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= RPT_ZERO;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  assign rpt_s = 1'b0;
`endif

  // Control word updates, one cycle behind the event pulses.
  always_comb begin
    key_evt_d    = press_s | {1'b0, rpt_s, 1'b0};
    wave_sel_d   = wave_sel_q;
    idx_d        = idx_q;
    freq_word_d  = freq_word_q;
    phase_word_d = phase_word_q;
    if (key_evt_q[0]) begin
      wave_sel_d = wave_sel_q + 2'd1;
    end else begin
      wave_sel_d = wave_sel_q;
    end
    if (key_evt_q[1]) begin
      idx_d       = (idx_q == IDX_MAX) ? IDX_ZERO : idx_q + IDX_W'(1);
      freq_word_d = FREQ_BASE << idx_d;
    end else begin
      idx_d       = idx_q;
      freq_word_d = freq_word_q;
    end
    if (key_evt_q[2]) begin
      phase_word_d = phase_word_q + PHASE_STEP;
    end else begin
      phase_word_d = phase_word_q;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_evt_q    <= 3'b000;
      wave_sel_q   <= 2'd0;
      idx_q        <= IDX_ZERO;
      freq_word_q  <= FREQ_BASE;
      phase_word_q <= 12'd0;
    end else begin
      key_evt_q    <= key_evt_d;
      wave_sel_q   <= wave_sel_d;
      idx_q        <= idx_d;
      freq_word_q  <= freq_word_d;
      phase_word_q <= phase_word_d;
    end
  end

  assign key_evt    = key_evt_q;
  assign wave_sel   = wave_sel_q;
  assign freq_word  = freq_word_q;
  assign phase_word = phase_word_q;

endmodule

// File: tb/tb_dds_key_ctrl.sv
// Directed bench for dds_key_ctrl with a short debounce period (16 cycles).
module tb_dds_key_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  keys = 3'b111;
  logic [1:0]  wave_sel;
  logic [31:0] freq_word;
  logic [11:0] phase_word;
  logic [2:0]  key_evt;

  int errors = 0;
  int checks = 0;
  int evt_cnt [3] = '{0, 0, 0};
  int evt101_cnt = 0;
  int lat;
  int snap0, snap1, snap2, snap101;

  localparam logic [31:0] BASE = 32'd85899;

  dds_key_ctrl #(
    .DEBOUNCE_CYC(16)
`ifdef DDS_KEY_AUTO_REPEAT_EN
    , .REPEAT_CYC(32)
`endif
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key0_in   (keys[0]),
    .key1_in   (keys[1]),
    .key2_in   (keys[2]),
    .wave_sel  (wave_sel),
    .freq_word (freq_word),
    .phase_word(phase_word),
    .key_evt   (key_evt)
  );

  always #5 clk = ~clk;

  // Event tally, sampled on the falling edge.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (key_evt[k]) evt_cnt[k] <= evt_cnt[k] + 1;
    end
    if (key_evt == 3'b101) evt101_cnt <= evt101_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_evt(input int k, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!key_evt[k] && n < 40);
  endtask

  task automatic press(input logic [2:0] mask, input int hold);
    @(negedge clk);
    keys = keys & ~mask;
    repeat (hold) @(negedge clk);
    keys = keys | mask;
    repeat (40) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_wave", 32'(wave_sel), 32'd0);
    check("rst_freq", freq_word, BASE);
    check("rst_phase", 32'(phase_word), 32'd0);
    check("rst_evt", 32'(key_evt), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // First key1 press: latency and single event.
    snap1 = evt_cnt[1];
    keys[1] = 1'b0;
    wait_evt(1, lat);
    check("k1_latency", 32'(lat), 32'd19);
    repeat (21) @(negedge clk);
    keys[1] = 1'b1;
    repeat (40) @(negedge clk);
    check("k1_one_evt", 32'(evt_cnt[1] - snap1), 32'd1);
    check("freq_idx1", freq_word, BASE << 1);

    for (int i = 2; i <= 7; i++) begin
      press(3'b010, 40);
      check("freq_step", freq_word, BASE << i);
    end
    check("freq_max", freq_word, 32'd10995072);
    press(3'b010, 40);
    check("freq_wrap", freq_word, BASE);

    // key0 with bounce ahead of a solid press.
    snap0 = evt_cnt[0];
    for (int i = 0; i < 3; i++) begin
      keys[0] = 1'b0;
      repeat (5) @(negedge clk);
      keys[0] = 1'b1;
      repeat (5) @(negedge clk);
    end
    keys[0] = 1'b0;
    repeat (40) @(negedge clk);
    keys[0] = 1'b1;
    repeat (40) @(negedge clk);
    check("k0_bounce_evts", 32'(evt_cnt[0] - snap0), 32'd1);
    check("wave_1", 32'(wave_sel), 32'd1);
    for (int i = 2; i <= 5; i++) begin
      press(3'b001, 40);
      check("wave_step", 32'(wave_sel), 32'(i % 4));
    end

    for (int i = 1; i <= 4; i++) begin
      press(3'b100, 40);
      check("phase_step", 32'(phase_word), 32'((i * 1024) % 4096));
    end

    // key0 and key2 together.
    snap0 = evt_cnt[0];
    snap2 = evt_cnt[2];
    snap101 = evt101_cnt;
    press(3'b101, 40);
    check("both_101", 32'(evt101_cnt - snap101), 32'd1);
    check("both_k0", 32'(evt_cnt[0] - snap0), 32'd1);
    check("both_k2", 32'(evt_cnt[2] - snap2), 32'd1);
    check("both_wave", 32'(wave_sel), 32'd2);
    check("both_phase", 32'(phase_word), 32'd1024);

    // Reset part-way through key1's press filter.
    snap1 = evt_cnt[1];
    keys[1] = 1'b0;
    repeat (13) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rst_evts", 32'(evt_cnt[1] - snap1), 32'd0);
    check("mid_rst_freq", freq_word, BASE);
    check("mid_rst_wave", 32'(wave_sel), 32'd0);
    check("mid_rst_phase", 32'(phase_word), 32'd0);
    rst_n = 1'b1;
    wait_evt(1, lat);
    check("held_latency", 32'(lat), 32'd19);
    repeat (100 - 19) @(negedge clk);
    keys[1] = 1'b1;
    repeat (40) @(negedge clk);
`ifdef DDS_KEY_AUTO_REPEAT_EN
    check("held_evts", 32'(evt_cnt[1] - snap1), 32'd3);
    check("held_freq", freq_word, BASE << 3);
`else
    check("held_evts", 32'(evt_cnt[1] - snap1), 32'd1);
    check("held_freq", freq_word, BASE << 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
